sm_fv_stream_buffer: RTL and testbench

Per-bank elastic buffer directly downstream of the big-FV bank controller. It accepts the feature-vector line stream that the big-FV bank emits toward the small-FV stage for one replay iteration. It holds the lines in a small circular FIFO and hands them in order to the small-FV consumer over a valid/ready handshake. It also tracks iteration boundaries, checks the streamed line count against `FV_num`, and reports per-iteration completion. One instance is placed per bank, `Num_Banks_all_FV` instances in total.

---
 rtl/sm_fv_stream_buffer_pkg.sv | 20 ++
 rtl/sm_fv_fifo_core.sv | 59 +++++
 rtl/sm_fv_stream_buffer.sv | 108 ++++++++++
 tb/tb_sm_fv_stream_buffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_fv_stream_buffer_pkg.sv
// Shared types and default sizing for the small-FV stream buffer.
package sm_fv_stream_buffer_pkg;

    localparam int FV_bandwidth = 16;
    localparam int Max_FV_num   = 16;
    localparam int SM_FV_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } sm_fv_state_e;

    typedef struct packed {
        logic [$clog2(Max_FV_num)-1:0] fv_idx;
        logic [FV_bandwidth-1:0]       data;
        logic                          last;
    } FV_line_pkt;

endpackage

// File: rtl/sm_fv_fifo_core.sv
// Circular register FIFO with push/pop/flush; read data is combinational at the read pointer.
module sm_fv_fifo_core
    import sm_fv_stream_buffer_pkg::*;
#(
    parameter int DEPTH = SM_FV_DEPTH,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (occupancy != OCC_W'(DEPTH));
    assign do_pop  = pop && (occupancy != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            // Storage is cleared so the head output reads zero out of reset.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (do_pop && !do_push) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

endmodule

// File: rtl/sm_fv_stream_buffer.sv
// Per-bank elastic buffer between the big-FV bank and the small-FV stage, with iteration tracking.
module sm_fv_stream_buffer
    import sm_fv_stream_buffer_pkg::*;
#(
    parameter int DEPTH  = SM_FV_DEPTH,
    parameter int DATA_W = FV_bandwidth,
    parameter int IDX_W  = $clog2(Max_FV_num),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  FV_num,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_fv_idx,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_fv_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              iter_done,
    output logic              len_err,
    output logic [OCC_W-1:0]  occupancy
);

    sm_fv_state_e      state;
    logic [IDX_W-1:0]  count;
    logic [IDX_W-1:0]  fv_num_q;
    logic [IDX_W:0]    count_inc;
    logic              push;
    logic              pop;
    logic              drain_empty;
    logic [IDX_W+DATA_W-1:0] rd_word;

    assign in_ready    = (state == STREAM) && (occupancy < OCC_W'(DEPTH));
    assign out_valid   = (occupancy != '0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign busy        = (state != IDLE);
    assign count_inc   = {1'b0, count} + (IDX_W + 1)'(1);
    // FIFO goes empty at this edge; no pushes can happen outside STREAM.
    assign drain_empty = (occupancy == '0) || ((occupancy == OCC_W'(1)) && pop);
    assign out_fv_idx  = rd_word[IDX_W+DATA_W-1:DATA_W];
    assign out_data    = rd_word[DATA_W-1:0];

    sm_fv_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (IDX_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .wr_data   ({in_fv_idx, in_data}),
        .rd_data   (rd_word),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            fv_num_q  <= '0;
            len_err   <= 1'b0;
            iter_done <= 1'b0;
        end else begin
            iter_done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= STREAM;
                            fv_num_q <= FV_num;
                            count    <= '0;
                            len_err  <= 1'b0;
                        end
                    end
                    STREAM: begin
                        if (push) begin
                            count <= (&count) ? count : count_inc[IDX_W-1:0];
                            if (in_last) begin
                                state <= DRAIN;
                                if (count_inc != {1'b0, fv_num_q}) begin
                                    len_err <= 1'b1;
                                end
                            end
                        end
                    end
                    DRAIN: begin
                        if (drain_empty) begin
                            state     <= IDLE;
                            iter_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sm_fv_stream_buffer.sv
// Scoreboard bench: accepted lines queue their expected head values; a monitor checks every pop.
module tb_sm_fv_stream_buffer;
    import sm_fv_stream_buffer_pkg::*;

    localparam int DW = FV_bandwidth;
    localparam int IW = $clog2(Max_FV_num);
    localparam int OW = $clog2(SM_FV_DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] FV_num = '0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_fv_idx = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_fv_idx;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          iter_done;
    logic          len_err;
    logic [OW-1:0] occupancy;

    int vectors = 0;
    int miscompares = 0;
    int iter_cnt = 0;
    FV_line_pkt exp_q[$];

    sm_fv_stream_buffer #(
        .DEPTH  (SM_FV_DEPTH),
        .DATA_W (DW),
        .IDX_W  (IW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .FV_num     (FV_num),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fv_idx  (in_fv_idx),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fv_idx (out_fv_idx),
        .out_data   (out_data),
        .busy       (busy),
        .iter_done  (iter_done),
        .len_err    (len_err),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && iter_done) iter_cnt++;
    end

    // Pops happen at the next rising edge; compare the head against the oldest expectation.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got idx=%0d data=%h, required no pop", out_fv_idx, out_data);
            end else begin
                FV_line_pkt e;
                e = exp_q.pop_front();
                if (out_fv_idx !== e.fv_idx || out_data !== e.data) begin
                    miscompares++;
                    $display("FAIL pop_order: got idx=%0d data=%h, required idx=%0d data=%h",
                             out_fv_idx, out_data, e.fv_idx, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic start_iter(input logic [IW-1:0] n);
        start = 1'b1;
        FV_num = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_line(input logic [IW-1:0] idx, input logic [DW-1:0] d, input logic last);
        bit got = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_fv_idx = idx;
        in_data = d;
        in_last = last;
        while (!got && n < 40) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                exp_q.push_back('{fv_idx: idx, data: d, last: last});
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!got) check("send_accept", 32'(got), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),   32'd0);
        check({tag, "_out_valid"}, 32'(out_valid),  32'd0);
        check({tag, "_out_idx"},   32'(out_fv_idx), 32'd0);
        check({tag, "_out_data"},  32'(out_data),   32'd0);
        check({tag, "_busy"},      32'(busy),       32'd0);
        check({tag, "_iter_done"}, 32'(iter_done),  32'd0);
        check({tag, "_len_err"},   32'(len_err),    32'd0);
        check({tag, "_occ"},       32'(occupancy),  32'd0);
    endtask

    initial begin
        int iters;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset = 1'b1;

        // Three back-to-back lines, consumer always ready
        out_ready = 1'b1;
        start_iter(4'd3);
        send_line(4'd0, 16'h1100, 1'b0);
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        send_line(4'd1, 16'h1101, 1'b0);
        send_line(4'd2, 16'h1102, 1'b1);
        wait_idle();
        check("t1_iter_cnt", 32'(iter_cnt), 32'd1);
        check("t1_len_err", 32'(len_err), 32'd0);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure to full, no bypass while full
        out_ready = 1'b0;
        start_iter(4'd5);
        for (int i = 0; i < 4; i++) send_line(IW'(i), 16'h2200 + 16'(i), 1'b0);
        in_valid = 1'b1;
        in_fv_idx = 4'd4;
        in_data = 16'h2204;
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t2_full_in_ready", 32'(in_ready), 32'd0);
        check("t2_full_occ", 32'(occupancy), 32'd4);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_no_bypass", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        send_line(4'd4, 16'h2204, 1'b1);
        wait_idle();
        check("t2_iter_cnt", 32'(iter_cnt), 32'd2);
        check("t2_len_err", 32'(len_err), 32'd0);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Simultaneous push/pop at occupancy 2, ten lines across pointer wrap
        out_ready = 1'b0;
        start_iter(4'd10);
        send_line(4'd0, 16'h3300, 1'b0);
        send_line(4'd1, 16'h3301, 1'b0);
        out_ready = 1'b1;
        for (int i = 2; i < 10; i++) begin
            send_line(IW'(i), 16'h3300 + 16'(i), (i == 9));
            check("t3_occ_steady", 32'(occupancy), 32'd2);
        end
        wait_idle();
        check("t3_iter_cnt", 32'(iter_cnt), 32'd3);
        check("t3_len_err", 32'(len_err), 32'd0);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Short iteration raises len_err; next start clears it
        start_iter(4'd4);
        send_line(4'd0, 16'h4400, 1'b0);
        send_line(4'd1, 16'h4401, 1'b0);
        send_line(4'd2, 16'h4402, 1'b1);
        wait_idle();
        check("t4_len_err_set", 32'(len_err), 32'd1);
        check("t4_iter_cnt", 32'(iter_cnt), 32'd4);
        start_iter(4'd1);
        check("t4_len_err_clr", 32'(len_err), 32'd0);
        send_line(4'd0, 16'h4410, 1'b1);
        wait_idle();
        check("t4_len_err_ok", 32'(len_err), 32'd0);
        iters = iter_cnt;
        check("t4_iter_cnt2", 32'(iters), 32'd5);

        // Flush mid-stream
        out_ready = 1'b0;
        start_iter(4'd5);
        send_line(4'd0, 16'h5500, 1'b0);
        send_line(4'd1, 16'h5501, 1'b0);
        send_line(4'd2, 16'h5502, 1'b0);
        @(negedge clk);
        check("t5_occ_pre", 32'(occupancy), 32'd3);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t5_occ", 32'(occupancy), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check("t5_no_iter_done", 32'(iter_cnt), 32'(iters));

        // Reset mid-DRAIN, then a normal iteration
        start_iter(4'd2);
        send_line(4'd0, 16'h6600, 1'b0);
        send_line(4'd1, 16'h6601, 1'b1);
        @(negedge clk);
        check("t6_in_drain", 32'(busy), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("t6");
        @(posedge clk); #1;
        out_ready = 1'b1;
        start_iter(4'd1);
        send_line(4'd7, 16'h6677, 1'b1);
        wait_idle();
        check("t6_iter_cnt", 32'(iter_cnt), 32'(iters + 1));
        check("t6_len_err", 32'(len_err), 32'd0);
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
